// File: rtl/soc_pio_pkg.sv
// Shared definitions for the parameterised Avalon-MM PIO bank: register map,
// edge-select encoding and bus width.
package soc_pio_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    localparam logic [2:0] REG_DATA    = 3'd0;
    localparam logic [2:0] REG_DIR     = 3'd1;
    localparam logic [2:0] REG_IRQMASK = 3'd2;
    localparam logic [2:0] REG_EDGECAP = 3'd3;
    localparam logic [2:0] REG_OUTSET  = 3'd4;
    localparam logic [2:0] REG_OUTCLR  = 3'd5;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

endpackage

// File: rtl/soc_pio_edge_detect.sv
// Pin synchroniser (SYNC_STAGES flops) followed by a delay flop; emits the
// synchronised pin value and a per-bit one-cycle edge pulse of the selected type.
module soc_pio_edge_detect
    import soc_pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter edge_type_e  EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] edge_o
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] dly_q;
    logic [WIDTH-1:0] dly_d;

    always_comb begin
        sync_d[0] = pin_i;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        dly_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            dly_q <= '0;
        end else begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            dly_q <= dly_d;
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];

    always_comb begin
        case (EDGE_TYPE)
            EDGE_FALL: edge_o = ~sync_o & dly_q;
            EDGE_ANY:  edge_o = sync_o ^ dly_q;
            default:   edge_o = sync_o & ~dly_q;
        endcase
    end

endmodule

// File: rtl/soc_pio_gen2.sv
// Avalon-MM GPIO bank: data/direction registers, atomic set/clear, synchronised
// inputs; edge capture + IRQ built only when SOC_PIO_EDGE_IRQ_EN is defined.
module soc_pio_gen2
    import soc_pio_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 16,
    parameter int unsigned           SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [DATA_WIDTH-1:0] DIR_RESET   = '0,
    parameter int unsigned           EDGE_TYPE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] oe_port,
    output logic                  irq
);

    localparam edge_type_e EDGE_SEL = edge_type_e'(2'(EDGE_TYPE));

    logic                  wr;
    logic [DATA_WIDTH-1:0] wd;
    logic [DATA_WIDTH-1:0] sync_in;
    logic [DATA_WIDTH-1:0] edge_pulse;
    logic [DATA_WIDTH-1:0] rd_val;

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] dir_q, dir_d;
    logic [31:0]           readdata_q, readdata_d;

    logic unused_wd;
    assign unused_wd = ^writedata;

    assign wr = chipselect & ~write_n;
    assign wd = writedata[DATA_WIDTH-1:0];

    soc_pio_edge_detect #(
        .WIDTH       (DATA_WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_SEL)
    ) u_edge (
        .clk    (clk),
        .reset  (reset),
        .pin_i  (in_port),
        .sync_o (sync_in),
        .edge_o (edge_pulse)
    );

`ifdef SOC_PIO_EDGE_IRQ_EN
    localparam logic [2:0] GUARD_INIT = 3'(SYNC_STAGES + 1);

    logic [DATA_WIDTH-1:0] irqmask_q, irqmask_d;
    logic [DATA_WIDTH-1:0] edgecap_q, edgecap_d;
    logic [2:0]            guard_q, guard_d;

    // Guard spans the chain fill after reset so a pin held high cannot look like an edge.
    always_comb begin
        irqmask_d = irqmask_q;
        edgecap_d = edgecap_q;
        guard_d   = (guard_q != '0) ? guard_q - 3'd1 : guard_q;
        if (wr && address == REG_IRQMASK) begin
            irqmask_d = wd;
        end
        if (wr && address == REG_EDGECAP) begin
            edgecap_d = edgecap_q & ~wd;
        end
        if (guard_q == '0) begin
            edgecap_d = edgecap_d | edge_pulse;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask_q <= '0;
            edgecap_q <= '0;
            guard_q   <= GUARD_INIT;
        end else begin
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
            guard_q   <= guard_d;
        end
    end

    assign irq = |(edgecap_q & irqmask_q);
`else
    logic unused_edge;
    assign unused_edge = ^edge_pulse;
    assign irq         = 1'b0;
`endif

    always_comb begin
        data_d = data_q;
        dir_d  = dir_q;
        if (wr) begin
            case (address)
                REG_DATA:   data_d = wd;
                REG_DIR:    dir_d  = wd;
                REG_OUTSET: data_d = data_q | wd;
                REG_OUTCLR: data_d = data_q & ~wd;
                default:    ;
            endcase
        end
    end

    always_comb begin
        case (address)
            REG_DATA:    rd_val = (sync_in & ~dir_q) | (data_q & dir_q);
            REG_DIR:     rd_val = dir_q;
`ifdef SOC_PIO_EDGE_IRQ_EN
            REG_IRQMASK: rd_val = irqmask_q;
            REG_EDGECAP: rd_val = edgecap_q;
`endif
            default:     rd_val = '0;
        endcase
        readdata_d                 = '0;
        readdata_d[DATA_WIDTH-1:0] = rd_val;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= RESET_VALUE;
            dir_q      <= DIR_RESET;
            readdata_q <= '0;
        end else begin
            data_q     <= data_d;
            dir_q      <= dir_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign out_port = data_q;
    assign oe_port  = dir_q;

endmodule
